pool_tile_sequencer: RTL and testbench

- Job-level controller for the average/max pooling datapath (avr_pooling_unrolled).
- Accepts one job descriptor per handshake, then runs cfg_n_tiles pooling operations on that datapath.
- Per tile: issues input-buffer reads, drives the datapath's start/en/size/pool_sel, waits for its done, then serialises the four 16-bit pooled results into the output buffer.
- Sits between the layer scheduler (descriptor side) and the pooling datapath plus its input/output SRAMs.

---
 rtl/pool_seq_pkg.sv | 34 +++
 rtl/pool_seq_wdog.sv | 42 ++++
 rtl/pool_tile_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_pool_tile_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_seq_pkg
//  Description : Shared types and constants for the pooling tile sequencer:
//                FSM state encoding, results-per-tile count and the
//                input-buffer read latency that sets the pu_en delay.
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_seq_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_FEED      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WRITE     = 3'd4,
        S_FIN       = 3'd5
    } seq_state_t;

    // Pooled results produced by the datapath per tile
    localparam int N_OUT = 4;

    // Input SRAM read latency in cycles
    localparam int RD_LAT = 1;

    // pu_en must trail rd_en by exactly the read latency so data and valid align
    localparam int PU_EN_DLY = RD_LAT;

    // Width of the result index used while serialising the write burst
    localparam int KW = $clog2(N_OUT);

endpackage : pool_seq_pkg
`default_nettype wire

// File: rtl/pool_seq_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : pool_seq_wdog
//  Description : Loadable down-counter guarding the wait for the datapath's
//                done pulse. Loaded with TIMEOUT-1 on entry to the wait, it
//                decrements once per enabled cycle and reports expiry when it
//                reaches zero, i.e. during the TIMEOUT-th waiting cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_seq_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int              CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   c_load = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Clear has priority, then load, then saturating decrement while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule : pool_seq_wdog
`default_nettype wire

// File: rtl/pool_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pool_tile_sequencer
//  Description : Job-level controller for the pooling datapath. Accepts one
//                descriptor, then per tile: pulses start, streams size_1
//                input-buffer reads (pu_en trails rd_en by the read latency),
//                waits for the datapath's done under a watchdog, and writes
//                the four pooled results to consecutive output addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_tile_sequencer
    import pool_seq_pkg::*;
#(
    parameter int AW      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_fsm,
    input  logic          abort,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [4:0]    cfg_size_1,
    input  logic [4:0]    cfg_size_2,
    input  logic          cfg_pool_sel,
    input  logic [7:0]    cfg_n_tiles,
    input  logic [AW-1:0] cfg_rd_base,
    input  logic [AW-1:0] cfg_wr_base,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          pu_start,
    output logic          pu_en,
    output logic [4:0]    pu_size_1,
    output logic [4:0]    pu_size_2,
    output logic          pu_pool_sel,
    input  logic          pu_done,
    input  logic [15:0]   pu_o_1,
    input  logic [15:0]   pu_o_2,
    input  logic [15:0]   pu_o_3,
    input  logic [15:0]   pu_o_4,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [KW-1:0] c_last_k = KW'(N_OUT - 1);

    seq_state_t            r_state;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [7:0]            r_n_tiles;
    logic [7:0]            r_tile_cnt;
    logic [4:0]            r_beat;
    logic [KW-1:0]         r_k;
    logic [15:0]           r_res [0:N_OUT-1];
    logic [PU_EN_DLY-1:0]  r_en_pipe;

    logic                  w_kill;
    logic                  w_feed_last;
    logic                  w_wd_load;
    logic                  w_wd_en;
    logic                  w_wd_expired;
    logic [KW-1:0]         w_k_next;

    // Abort only acts on a running job; in IDLE it is ignored entirely
    assign w_kill      = abort && (r_state != S_IDLE);
    assign w_feed_last = (r_beat == (pu_size_1 - 5'd1));
    assign w_wd_load   = (r_state == S_FEED) && w_feed_last;
    assign w_wd_en     = (r_state == S_WAIT_DONE);
    assign w_k_next    = r_k + KW'(1);

    pool_seq_wdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst_fsm),
        .i_clr     (w_kill),
        .i_load    (w_wd_load),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // pu_en is rd_en delayed by the SRAM read latency; flushed on abort
    always_ff @(posedge clk or posedge rst_fsm) begin
        if (rst_fsm) begin
            r_en_pipe <= '0;
        end else if (w_kill) begin
            r_en_pipe <= '0;
        end else begin
            r_en_pipe[0] <= rd_en;
            for (int i = 1; i < PU_EN_DLY; i++) begin
                r_en_pipe[i] <= r_en_pipe[i-1];
            end
        end
    end

    assign pu_en = r_en_pipe[PU_EN_DLY-1];

    // Main sequencer: every output is registered from the state being entered
    always_ff @(posedge clk or posedge rst_fsm) begin
        if (rst_fsm) begin
            r_state     <= S_IDLE;
            cfg_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            pu_start    <= 1'b0;
            pu_size_1   <= '0;
            pu_size_2   <= '0;
            pu_pool_sel <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_n_tiles   <= '0;
            r_tile_cnt  <= '0;
            r_beat      <= '0;
            r_k         <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_res[i] <= '0;
            end
        end else if (w_kill) begin
            r_state   <= S_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            pu_start  <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            done     <= 1'b0;
            pu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cfg_valid && cfg_ready) begin
                        pu_size_1   <= cfg_size_1;
                        pu_size_2   <= cfg_size_2;
                        pu_pool_sel <= cfg_pool_sel;
                        r_n_tiles   <= cfg_n_tiles;
                        r_rd_ptr    <= cfg_rd_base;
                        r_wr_ptr    <= cfg_wr_base;
                        r_tile_cnt  <= '0;
                        err         <= 1'b0;
                        cfg_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if ((cfg_n_tiles == 8'd0) || (cfg_size_1 == 5'd0)) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_START;
                            pu_start <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state  <= S_FEED;
                    rd_en    <= 1'b1;
                    rd_addr  <= r_rd_ptr;
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_beat   <= '0;
                end
                S_FEED: begin
                    if (w_feed_last) begin
                        rd_en   <= 1'b0;
                        r_state <= S_WAIT_DONE;
                    end else begin
                        rd_addr  <= r_rd_ptr;
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        r_beat   <= r_beat + 5'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (pu_done) begin
                        r_res[0] <= pu_o_1;
                        r_res[1] <= pu_o_2;
                        r_res[2] <= pu_o_3;
                        r_res[3] <= pu_o_4;
                        wr_en    <= 1'b1;
                        wr_addr  <= r_wr_ptr;
                        wr_data  <= pu_o_1;
                        r_k      <= '0;
                        r_state  <= S_WRITE;
                    end else if (w_wd_expired) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_WRITE: begin
                    if (r_k == c_last_k) begin
                        wr_en      <= 1'b0;
                        r_wr_ptr   <= r_wr_ptr + AW'(N_OUT);
                        r_tile_cnt <= r_tile_cnt + 8'd1;
                        if ((r_tile_cnt + 8'd1) == r_n_tiles) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_START;
                            pu_start <= 1'b1;
                        end
                    end else begin
                        r_k     <= w_k_next;
                        wr_addr <= r_wr_ptr + AW'(w_k_next);
                        wr_data <= r_res[w_k_next];
                    end
                end
                S_FIN: begin
                    r_state   <= S_IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                    wr_en     <= 1'b0;
                end
            endcase
        end
    end

endmodule : pool_tile_sequencer
`default_nettype wire

// File: tb/tb_pool_tile_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pool_tile_sequencer
//  Description : Self-checking bench for pool_tile_sequencer. A responder
//                plays the pooling datapath, a monitor records the strobes,
//                and each scenario task compares the record with the trace
//                expected from the descriptor arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_tile_sequencer;

    localparam int AW      = 10;
    localparam int TIMEOUT = 64;

    logic          clk, rst_fsm, abort, cfg_valid, cfg_ready;
    logic [4:0]    cfg_size_1, cfg_size_2;
    logic          cfg_pool_sel;
    logic [7:0]    cfg_n_tiles;
    logic [AW-1:0] cfg_rd_base, cfg_wr_base;
    logic          rd_en, pu_start, pu_en, pu_pool_sel, pu_done, wr_en, busy, done, err;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [4:0]    pu_size_1, pu_size_2;
    logic [15:0]   pu_o_1, pu_o_2, pu_o_3, pu_o_4, wr_data;

    pool_tile_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_fsm(rst_fsm), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_size_1(cfg_size_1), .cfg_size_2(cfg_size_2), .cfg_pool_sel(cfg_pool_sel),
        .cfg_n_tiles(cfg_n_tiles), .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .pu_start(pu_start), .pu_en(pu_en),
        .pu_size_1(pu_size_1), .pu_size_2(pu_size_2), .pu_pool_sel(pu_pool_sel),
        .pu_done(pu_done), .pu_o_1(pu_o_1), .pu_o_2(pu_o_2), .pu_o_3(pu_o_3), .pu_o_4(pu_o_4),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Records and stimulus controls shared between processes
    logic [AW-1:0] obs_rd[$];
    logic [AW-1:0] obs_wa[$];
    logic [15:0]   obs_wd[$];
    logic [15:0]   resp_vals[$];
    int            obs_burst[$];
    int            n_start, n_done, n_pu_en, n_lag_err;
    logic          resp_on, resp_fixed, lag_on;
    int            resp_delay;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : global_guard
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 400000", $time);
        $fatal(1);
    end

    // Datapath stand-in: pu_done arrives resp_delay cycles after the last pu_en
    initial begin : responder
        int   wait_left;
        logic prev_en;
        wait_left = 0;
        prev_en   = 1'b0;
        pu_done   = 1'b0;
        pu_o_1 = '0; pu_o_2 = '0; pu_o_3 = '0; pu_o_4 = '0;
        forever begin
            @(negedge clk);
            pu_done = 1'b0;
            if (wait_left == 0 && resp_on && prev_en && !pu_en) wait_left = resp_delay;
            if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) begin
                    if (resp_fixed) begin
                        pu_o_1 = 16'd1; pu_o_2 = 16'd2; pu_o_3 = 16'd3; pu_o_4 = 16'd4;
                    end else begin
                        pu_o_1 = 16'($urandom); pu_o_2 = 16'($urandom);
                        pu_o_3 = 16'($urandom); pu_o_4 = 16'($urandom);
                    end
                    resp_vals.push_back(pu_o_1); resp_vals.push_back(pu_o_2);
                    resp_vals.push_back(pu_o_3); resp_vals.push_back(pu_o_4);
                    pu_done = 1'b1;
                end
            end
            prev_en = pu_en;
        end
    end

    // Strobe recorder, sampled mid-cycle
    initial begin : monitor
        logic prev_rd;
        int   burst;
        prev_rd = 1'b0;
        burst   = 0;
        forever begin
            @(negedge clk);
            if (rd_en === 1'b1) obs_rd.push_back(rd_addr);
            if (wr_en === 1'b1) begin obs_wa.push_back(wr_addr); obs_wd.push_back(wr_data); end
            if (pu_start === 1'b1) n_start++;
            if (done === 1'b1) n_done++;
            if (pu_en === 1'b1) begin n_pu_en++; burst++; end
            else if (burst > 0) begin obs_burst.push_back(burst); burst = 0; end
            if (lag_on && (pu_en !== prev_rd)) n_lag_err++;
            prev_rd = rd_en;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_obs();
        step(8);
        obs_rd.delete(); obs_wa.delete(); obs_wd.delete(); resp_vals.delete(); obs_burst.delete();
        n_start = 0; n_done = 0; n_pu_en = 0; n_lag_err = 0;
    endtask

    // Presents one descriptor and waits for the return to IDLE; cycles = -1 on hang
    task automatic run_job(input int n, input int s, input int s2, input int ps,
                           input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                           output int cycles, output logic [10:0] sz_obs);
        int guard;
        cfg_n_tiles = 8'(n); cfg_size_1 = 5'(s); cfg_size_2 = 5'(s2);
        cfg_pool_sel = 1'(ps); cfg_rd_base = rb; cfg_wr_base = wb;
        cfg_valid = 1'b1;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 20) begin step(1); guard++; end
        step(1);
        cfg_valid = 1'b0;
        sz_obs = {pu_pool_sel, pu_size_2, pu_size_1};
        cycles = 0;
        while (cfg_ready !== 1'b1 && cycles < 2000) begin step(1); cycles++; end
        if (cycles >= 2000) cycles = -1;
    endtask

    task automatic test_reset();
        step(3);
        n_checks++; if ({cfg_ready, busy, done, err, rd_en, pu_start, pu_en, wr_en} !== 8'b0)
            $display("FAIL reset_strobes: got %b want 00000000", {cfg_ready, busy, done, err, rd_en, pu_start, pu_en, wr_en}); else n_pass++;
        n_checks++; if ({rd_addr, wr_addr, wr_data, pu_size_1, pu_size_2, pu_pool_sel} !== '0)
            $display("FAIL reset_buses: rd_addr %h wr_addr %h wr_data %h size %h/%h want all 0", rd_addr, wr_addr, wr_data, pu_size_1, pu_size_2); else n_pass++;
        rst_fsm = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", cfg_ready); else n_pass++;
        step(1);
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_first_clock_ready: got %b want 1", cfg_ready); else n_pass++;
    endtask

    task automatic test_single_tile();
        int cyc; logic [10:0] sz;
        clear_obs();
        resp_on = 1'b1; resp_fixed = 1'b1; resp_delay = 2; lag_on = 1'b1;
        run_job(1, 2, 2, 0, 10'h010, 10'h100, cyc, sz);
        lag_on = 1'b0; resp_fixed = 1'b0;
        n_checks++; if (obs_rd.size() != 2) $display("FAIL single_rd_count: got %0d want 2", obs_rd.size()); else n_pass++;
        for (int i = 0; i < obs_rd.size() && i < 2; i++) begin
            n_checks++; if (obs_rd[i] !== 10'h010 + 10'(i)) $display("FAIL single_rd_addr[%0d]: got %h want %h", i, obs_rd[i], 10'h010 + 10'(i)); else n_pass++;
        end
        n_checks++; if (obs_wa.size() != 4) $display("FAIL single_wr_count: got %0d want 4", obs_wa.size()); else n_pass++;
        for (int k = 0; k < obs_wa.size() && k < 4; k++) begin
            n_checks++; if ({obs_wa[k], obs_wd[k]} !== {10'h100 + 10'(k), 16'(k + 1)})
                $display("FAIL single_write[%0d]: got %h:%h want %h:%h", k, obs_wa[k], obs_wd[k], 10'h100 + 10'(k), 16'(k + 1)); else n_pass++;
        end
        n_checks++; if (n_done != 1) $display("FAIL single_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL single_err: got %b want 0", err); else n_pass++;
        n_checks++; if (cyc != 11) $display("FAIL single_latency: got %0d want 11", cyc); else n_pass++;
        n_checks++; if (n_lag_err != 0) $display("FAIL single_pu_en_lag: got %0d errors want 0", n_lag_err); else n_pass++;
        n_checks++; if (sz !== {1'b0, 5'd2, 5'd2}) $display("FAIL single_pu_size: got %h want %h", sz, {1'b0, 5'd2, 5'd2}); else n_pass++;
    endtask

    task automatic test_multi_tile();
        int cyc; logic [10:0] sz;
        clear_obs();
        resp_on = 1'b1; resp_delay = 1; lag_on = 1'b1;
        run_job(3, 4, 3, 1, 10'h000, 10'h200, cyc, sz);
        lag_on = 1'b0;
        n_checks++; if (obs_rd.size() != 12) $display("FAIL multi_rd_count: got %0d want 12", obs_rd.size()); else n_pass++;
        for (int i = 0; i < obs_rd.size() && i < 12; i++) begin
            n_checks++; if (obs_rd[i] !== 10'(i)) $display("FAIL multi_rd_addr[%0d]: got %h want %h", i, obs_rd[i], 10'(i)); else n_pass++;
        end
        n_checks++; if (n_start != 3) $display("FAIL multi_start_count: got %0d want 3", n_start); else n_pass++;
        n_checks++; if (obs_burst.size() != 3) $display("FAIL multi_burst_count: got %0d want 3", obs_burst.size()); else n_pass++;
        foreach (obs_burst[b]) begin
            n_checks++; if (obs_burst[b] != 4) $display("FAIL multi_burst_len[%0d]: got %0d want 4", b, obs_burst[b]); else n_pass++;
        end
        n_checks++; if (n_lag_err != 0) $display("FAIL multi_pu_en_lag: got %0d errors want 0", n_lag_err); else n_pass++;
        n_checks++; if (obs_wa.size() != 12 || resp_vals.size() != 12)
            $display("FAIL multi_wr_count: got %0d writes want 12", obs_wa.size()); else n_pass++;
        for (int j = 0; j < obs_wa.size() && j < resp_vals.size(); j++) begin
            n_checks++; if ({obs_wa[j], obs_wd[j]} !== {10'h200 + 10'(j), resp_vals[j]})
                $display("FAIL multi_write[%0d]: got %h:%h want %h:%h", j, obs_wa[j], obs_wd[j], 10'h200 + 10'(j), resp_vals[j]); else n_pass++;
        end
        n_checks++; if (cyc != 34) $display("FAIL multi_latency: got %0d want 34", cyc); else n_pass++;
    endtask

    task automatic test_random_jobs();
        int cyc, n, s, s2, ps, d, exp_cyc;
        logic [AW-1:0] rb, wb, e;
        logic [10:0] sz;
        for (int job = 0; job < 12; job++) begin
            n  = $urandom_range(1, 4);
            s  = $urandom_range(1, 12);
            s2 = $urandom_range(0, 31);
            ps = $urandom_range(0, 1);
            d  = $urandom_range(1, 4);
            rb = (job == 0) ? 10'h3FD : AW'($urandom_range(0, 1023));
            wb = (job == 0) ? 10'h3FE : AW'($urandom_range(0, 1023));
            clear_obs();
            resp_on = 1'b1; resp_delay = d; lag_on = 1'b1;
            run_job(n, s, s2, ps, rb, wb, cyc, sz);
            lag_on = 1'b0;
            exp_cyc = n * (1 + s + (d + 1) + 4) + 1;
            n_checks++; if (cyc != exp_cyc) $display("FAIL rand%0d_latency: got %0d want %0d", job, cyc, exp_cyc); else n_pass++;
            n_checks++; if (obs_rd.size() != n * s) $display("FAIL rand%0d_rd_count: got %0d want %0d", job, obs_rd.size(), n * s); else n_pass++;
            for (int i = 0; i < obs_rd.size() && i < n * s; i++) begin
                e = rb + AW'(i);
                n_checks++; if (obs_rd[i] !== e) $display("FAIL rand%0d_rd_addr[%0d]: got %h want %h", job, i, obs_rd[i], e); else n_pass++;
            end
            n_checks++; if (obs_wa.size() != 4 * n || resp_vals.size() != 4 * n)
                $display("FAIL rand%0d_wr_count: got %0d want %0d", job, obs_wa.size(), 4 * n); else n_pass++;
            for (int j = 0; j < obs_wa.size() && j < resp_vals.size(); j++) begin
                e = wb + AW'(j);
                n_checks++; if ({obs_wa[j], obs_wd[j]} !== {e, resp_vals[j]})
                    $display("FAIL rand%0d_write[%0d]: got %h:%h want %h:%h", job, j, obs_wa[j], obs_wd[j], e, resp_vals[j]); else n_pass++;
            end
            n_checks++; if (n_start != n || n_done != 1 || n_pu_en != n * s)
                $display("FAIL rand%0d_counts: start %0d done %0d pu_en %0d want %0d 1 %0d", job, n_start, n_done, n_pu_en, n, n * s); else n_pass++;
            n_checks++; if (n_lag_err != 0 || err !== 1'b0) $display("FAIL rand%0d_lag_err: lag %0d err %b want 0 0", job, n_lag_err, err); else n_pass++;
            n_checks++; if (sz !== {1'(ps), 5'(s2), 5'(s)}) $display("FAIL rand%0d_pu_size: got %h want %h", job, sz, {1'(ps), 5'(s2), 5'(s)}); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int cyc; logic [10:0] sz;
        clear_obs();
        resp_on = 1'b0;
        run_job(2, 2, 1, 0, 10'h040, 10'h080, cyc, sz);
        n_checks++; if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else n_pass++;
        n_checks++; if (cyc != 1 + 2 + TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", cyc, 1 + 2 + TIMEOUT + 1); else n_pass++;
        n_checks++; if (n_done != 1 || n_start != 1) $display("FAIL timeout_pulses: done %0d start %0d want 1 1", n_done, n_start); else n_pass++;
        n_checks++; if (obs_wa.size() != 0) $display("FAIL timeout_no_write: got %0d writes want 0", obs_wa.size()); else n_pass++;
        step(3);
        n_checks++; if (err !== 1'b1) $display("FAIL timeout_err_sticky: got %b want 1", err); else n_pass++;
        clear_obs();
        resp_on = 1'b1; resp_delay = 1;
        run_job(1, 1, 1, 0, 10'h000, 10'h000, cyc, sz);
        n_checks++; if (err !== 1'b0 || n_done != 1) $display("FAIL timeout_err_cleared: err %b done %0d want 0 1", err, n_done); else n_pass++;
    endtask

    task automatic test_abort();
        int guard;
        clear_obs();
        resp_on = 1'b0;
        cfg_n_tiles = 8'd2; cfg_size_1 = 5'd4; cfg_size_2 = 5'd4; cfg_pool_sel = 1'b0;
        cfg_rd_base = 10'h020; cfg_wr_base = 10'h030;
        cfg_valid = 1'b1;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 20) begin step(1); guard++; end
        step(1);
        cfg_valid = 1'b0;
        step(3);
        n_checks++; if (rd_en !== 1'b1 || rd_addr !== 10'h022) $display("FAIL abort_third_beat: rd_en %b rd_addr %h want 1 022", rd_en, rd_addr); else n_pass++;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        n_checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) $display("FAIL abort_idle: cfg_ready %b busy %b want 1 0", cfg_ready, busy); else n_pass++;
        n_checks++; if ({rd_en, pu_en, pu_start, wr_en, done} !== 5'b0) $display("FAIL abort_strobes: got %b want 00000", {rd_en, pu_en, pu_start, wr_en, done}); else n_pass++;
        step(5);
        n_checks++; if (n_done != 0 || obs_rd.size() != 3 || err !== 1'b0)
            $display("FAIL abort_after: done %0d reads %0d err %b want 0 3 0", n_done, obs_rd.size(), err); else n_pass++;
        // abort while idle must not block a descriptor presented in the same cycle
        clear_obs();
        resp_on = 1'b1; resp_delay = 1;
        cfg_n_tiles = 8'd1; cfg_size_1 = 5'd1;
        abort = 1'b1; cfg_valid = 1'b1;
        step(1);
        abort = 1'b0; cfg_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_idle_accept: busy %b want 1", busy); else n_pass++;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 100) begin step(1); guard++; end
        n_checks++; if (n_done != 1 || obs_wa.size() != 4) $display("FAIL abort_idle_job: done %0d writes %0d want 1 4", n_done, obs_wa.size()); else n_pass++;
    endtask

    task automatic test_zero_tiles();
        int guard, cyc; logic [10:0] sz;
        clear_obs();
        resp_on = 1'b1; resp_delay = 1;
        cfg_n_tiles = 8'd0; cfg_size_1 = 5'd3; cfg_size_2 = 5'd3; cfg_pool_sel = 1'b1;
        cfg_rd_base = 10'h0AA; cfg_wr_base = 10'h0BB;
        cfg_valid = 1'b1;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 20) begin step(1); guard++; end
        step(1);
        cfg_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL zero_done_pulse: done %b busy %b want 1 1", done, busy); else n_pass++;
        step(1);
        n_checks++; if (done !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL zero_back_idle: done %b cfg_ready %b want 0 1", done, cfg_ready); else n_pass++;
        step(3);
        n_checks++; if (n_done != 1 || n_start != 0 || obs_rd.size() != 0 || obs_wa.size() != 0)
            $display("FAIL zero_no_activity: done %0d start %0d rd %0d wr %0d want 1 0 0 0", n_done, n_start, obs_rd.size(), obs_wa.size()); else n_pass++;
        clear_obs();
        run_job(2, 0, 1, 0, 10'h000, 10'h000, cyc, sz);
        n_checks++; if (cyc != 1 || n_done != 1 || n_start != 0 || obs_rd.size() != 0)
            $display("FAIL zero_size: cycles %0d done %0d start %0d rd %0d want 1 1 0 0", cyc, n_done, n_start, obs_rd.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int guard;
        clear_obs();
        resp_on = 1'b1; resp_delay = 1;
        cfg_n_tiles = 8'd2; cfg_size_1 = 5'd2; cfg_size_2 = 5'd2; cfg_pool_sel = 1'b0;
        cfg_rd_base = 10'h150; cfg_wr_base = 10'h250;
        cfg_valid = 1'b1;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 20) begin step(1); guard++; end
        step(1);
        cfg_valid = 1'b0;
        guard = 0;
        while (wr_en !== 1'b1 && guard < 50) begin step(1); guard++; end
        n_checks++; if (wr_en !== 1'b1) $display("FAIL rstw_reach_write: wr_en %b want 1", wr_en); else n_pass++;
        step(1);
        #2 rst_fsm = 1'b1;
        #1;
        n_checks++; if ({wr_en, busy, pu_start, rd_en, pu_en, done, cfg_ready} !== 7'b0)
            $display("FAIL rstw_async_clear: got %b want 0000000", {wr_en, busy, pu_start, rd_en, pu_en, done, cfg_ready}); else n_pass++;
        n_checks++; if (wr_addr !== '0 || wr_data !== '0) $display("FAIL rstw_buses: wr_addr %h wr_data %h want 0 0", wr_addr, wr_data); else n_pass++;
        step(1);
        rst_fsm = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0) $display("FAIL rstw_release_ready: got %b want 0", cfg_ready); else n_pass++;
        step(1);
        n_checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstw_first_clock: cfg_ready %b busy %b want 1 0", cfg_ready, busy); else n_pass++;
    endtask

    initial begin
        rst_fsm = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
        cfg_size_1 = '0; cfg_size_2 = '0; cfg_pool_sel = 1'b0; cfg_n_tiles = '0;
        cfg_rd_base = '0; cfg_wr_base = '0;
        resp_on = 1'b0; resp_fixed = 1'b0; resp_delay = 1; lag_on = 1'b0;
        n_start = 0; n_done = 0; n_pu_en = 0; n_lag_err = 0;
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_random_jobs();
        test_timeout();
        test_abort();
        test_zero_tiles();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pool_tile_sequencer
`default_nettype wire
